// File: rtl/disp_pkg.sv
// disp_pkg
//   Constants and types shared by the display pipeline: the VRAM read
//   controller, the pixel FIFO and the timing generator. Nothing here
//   depends on the active display resolution.
package disp_pkg;

    // Pixel and bus widths
    localparam int PIX_W          = 24;
    localparam int AXI_DW         = 32;
    localparam int AXI_BYTES      = AXI_DW / 8;

    // A read burst is 256 bytes, which is 64 beats of 32 bits
    localparam int BURST_BYTES    = 256;
    localparam int BURST_LEN_DEF  = BURST_BYTES / AXI_BYTES;

    // Pixel FIFO control state. It is derived from DISPON and the fill
    // level; there is no separate state register.
    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,    // display disabled, FIFO held flushed
        ST_FILLING   = 2'd1,    // enabled and empty
        ST_STREAMING = 2'd2     // enabled and holding at least one pixel
    } disp_fifo_state_e;

    function automatic disp_fifo_state_e fifo_state(input logic dispon,
                                                    input logic empty);
        if (!dispon) begin
            return ST_OFF;
        end else if (empty) begin
            return ST_FILLING;
        end
        return ST_STREAMING;
    endfunction

endpackage : disp_pkg

// File: rtl/disp_fifo_ram.sv
// disp_fifo_ram
//   Simple dual-port RAM for the pixel FIFO: one write port and one
//   synchronous read port with a single cycle of latency. A read and a
//   write to the same address in the same cycle return the old contents.
//
// Ports
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable; o_rdata updates on the next edge only when set
//   i_raddr  read address
//   o_rdata  registered read data
module disp_fifo_ram
    import disp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = PIX_W
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : disp_fifo_ram

// File: rtl/disp_pixfifo.sv
// disp_pixfifo
//   Pixel FIFO between the VRAM read controller and the display output
//   stage. Every accepted R-channel beat is stored; the display timing
//   side pops one 24-bit RGB pixel per PIXRD. DISPON low flushes
//   everything. BUF_WREADY tells the read controller a whole burst fits.
//
// Build option
//   DISP_PIXFIFO_STAT_EN  when defined, compiles in the sticky UNDERFLOW /
//                         OVERFLOW flags and a 16-bit saturating underflow
//                         counter. Otherwise both flags are tied to 0; the
//                         data path is the same in both builds.
//
// Ports
//   ACLK        clock
//   ARST        synchronous active-high reset
//   RDATA       AXI read data, pixel in [23:0], [31:24] ignored
//   RVALID      AXI read data valid
//   RREADY      AXI read ready (driven by the read controller)
//   DISPON      display enable; low flushes the FIFO
//   PIXRD       pop request
//   BUF_WREADY  at least BURST_LEN words free and DISPON high
//   PIXDATA     popped pixel, black when PIXVALID is low
//   PIXVALID    PIXDATA carries a real FIFO pixel this cycle
//   UNDERFLOW   sticky: pop requested while empty
//   OVERFLOW    sticky: beat dropped while full
module disp_pixfifo
    import disp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [AXI_DW-1:0] RDATA,
    input  logic              RVALID,
    input  logic              RREADY,
    input  logic              DISPON,
    input  logic              PIXRD,
    output logic              BUF_WREADY,
    output logic [PIX_W-1:0]  PIXDATA,
    output logic              PIXVALID,
    output logic              UNDERFLOW,
    output logic              OVERFLOW
);

    localparam int                  LP_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_FULL  = (DEPTH_LOG2+1)'(LP_DEPTH);
    localparam logic [DEPTH_LOG2:0] LP_BURST = (DEPTH_LOG2+1)'(BURST_LEN);

    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_pixvalid;

    disp_fifo_state_e      w_state;
    logic                  w_flush;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_req;
    logic                  w_pop_req;
    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic [PIX_W-1:0]      w_ram_q;
    logic [AXI_DW-PIX_W-1:0] w_unused_rdata;

    assign w_unused_rdata = RDATA[AXI_DW-1:PIX_W];

    assign w_state    = fifo_state(DISPON, (r_count == '0));
    assign w_flush    = (w_state == ST_OFF);
    assign w_empty    = (w_state == ST_FILLING);
    assign w_full     = (r_count == LP_FULL);

    assign w_push_req = RVALID & RREADY & DISPON;
    assign w_pop_req  = PIXRD & DISPON;

    // An empty pop never bypasses a same-cycle push; a full push is taken
    // only when a real pop frees its slot in the same cycle.
    assign w_pop_acc  = w_pop_req & ~w_empty;
    assign w_push_acc = w_push_req & (~w_full | w_pop_acc);

    always_ff @(posedge ACLK) begin
        if (ARST || w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pixvalid <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count    <= r_count + {{DEPTH_LOG2{1'b0}}, w_push_acc}
                                  - {{DEPTH_LOG2{1'b0}}, w_pop_acc};
            r_pixvalid <= w_pop_acc;
        end
    end

    disp_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (PIX_W)
    ) u_ram (
        .i_clk   (ACLK),
        .i_we    (w_push_acc),
        .i_waddr (r_wptr),
        .i_wdata (RDATA[PIX_W-1:0]),
        .i_re    (w_pop_acc),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    // The RAM output register holds the last read word; masking with the
    // registered valid gives black on reset, flush, underflow and idle.
    assign PIXDATA    = w_ram_q & {PIX_W{r_pixvalid}};
    assign PIXVALID   = r_pixvalid;

    assign BUF_WREADY = ~ARST & DISPON & ((LP_FULL - r_count) >= LP_BURST);

`ifdef DISP_PIXFIFO_STAT_EN
    logic        r_underflow;
    logic        r_overflow;
    logic [15:0] r_uf_cnt;
    logic        w_uf_evt;
    logic        w_ovf_evt;

    assign w_uf_evt  = w_pop_req & w_empty;
    assign w_ovf_evt = w_push_req & w_full & ~w_pop_acc;

    always_ff @(posedge ACLK) begin
        if (ARST || w_flush) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_uf_cnt    <= '0;
        end else begin
            if (w_uf_evt) begin
                r_underflow <= 1'b1;
                if (r_uf_cnt != 16'hFFFF) begin
                    r_uf_cnt <= r_uf_cnt + 16'd1;
                end
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign UNDERFLOW = r_underflow;
    assign OVERFLOW  = r_overflow;
`else
    assign UNDERFLOW = 1'b0;
    assign OVERFLOW  = 1'b0;
`endif

endmodule : disp_pixfifo

// File: tb/tb_disp_pixfifo.sv
// tb_disp_pixfifo
//   Directed scenarios followed by randomized traffic. A queue-based
//   reference model predicts every output after each clock edge.
module tb_disp_pixfifo;

    localparam int DEPTH = 512;
    localparam int BURST = 64;

    logic        ACLK;
    logic        ARST;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        DISPON;
    logic        PIXRD;
    logic        BUF_WREADY;
    logic [23:0] PIXDATA;
    logic        PIXVALID;
    logic        UNDERFLOW;
    logic        OVERFLOW;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [23:0] mq[$];
    logic        m_pv;
    logic [23:0] m_pd;
    logic        m_uf;
    logic        m_ovf;

    disp_pixfifo #(
        .DEPTH_LOG2 (9),
        .BURST_LEN  (BURST)
    ) dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .DISPON     (DISPON),
        .PIXRD      (PIXRD),
        .BUF_WREADY (BUF_WREADY),
        .PIXDATA    (PIXDATA),
        .PIXVALID   (PIXVALID),
        .UNDERFLOW  (UNDERFLOW),
        .OVERFLOW   (OVERFLOW)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply the rules to the inputs sampled at this edge.
    task automatic model_edge();
        int   n;
        logic popped;
        if (ARST || !DISPON) begin
            mq.delete();
            m_pv  = 1'b0;
            m_pd  = '0;
            m_uf  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            n      = mq.size();
            popped = 1'b0;
            m_pv   = 1'b0;
            m_pd   = '0;
            if (PIXRD) begin
                if (n > 0) begin
                    m_pd   = mq[0];
                    m_pv   = 1'b1;
                    popped = 1'b1;
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (popped) void'(mq.pop_front());
            if (RVALID && RREADY) begin
                if (n < DEPTH || popped) mq.push_back(RDATA[23:0]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        exp_rdy = !ARST && DISPON && ((DEPTH - mq.size()) >= BURST);
        chk("pixvalid", {31'd0, PIXVALID}, {31'd0, m_pv});
        chk("pixdata", {8'd0, PIXDATA}, {8'd0, m_pd});
        chk("buf_wready", {31'd0, BUF_WREADY}, {31'd0, exp_rdy});
        chk("count", {22'd0, dut.r_count}, mq.size());
`ifdef DISP_PIXFIFO_STAT_EN
        chk("underflow", {31'd0, UNDERFLOW}, {31'd0, m_uf});
        chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
`else
        chk("underflow", {31'd0, UNDERFLOW}, 32'd0);
        chk("overflow", {31'd0, OVERFLOW}, 32'd0);
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check.
    task automatic step(input logic rst, input logic don, input logic rv,
                        input logic rr, input logic prd, input logic [31:0] rd);
        ARST   = rst;
        DISPON = don;
        RVALID = rv;
        RREADY = rr;
        PIXRD  = prd;
        RDATA  = rd;
        @(posedge ACLK);
        model_edge();
        @(negedge ACLK);
        check_outputs();
    endtask

    initial begin
        logic fill_bias;
        ARST = 1'b1; DISPON = 1'b0; RVALID = 1'b0; RREADY = 1'b0;
        PIXRD = 1'b0; RDATA = '0;
        @(negedge ACLK);

        // Reset, including reset with traffic present
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, $urandom);
        // Enabled and idle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // One burst in, then drained in order
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFF00_0000 + i);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);  // valid without ready
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Fill to full, then one extra beat is dropped
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5A5A_5A5A);
        // Full with push and pop together
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00AB_CDEF);
        // Drain: the last word out is ABCDEF
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);

        // Empty pop with same-cycle push, then pop that word
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0012_3456);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Fill to 100 with flags set, one-cycle flush with a beat present
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);

        // Reset in the middle of a burst; remaining beats are normal pushes
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 44; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, $urandom);

        // Randomized traffic with alternating fill/drain bias
        fill_bias = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic rv, rr, prd, don, rst;
            if (i % 600 == 0) fill_bias = ~fill_bias;
            rv  = ($urandom % 8) != 0;
            rr  = fill_bias ? (($urandom % 8) != 0) : (($urandom % 3) == 0);
            prd = fill_bias ? (($urandom % 4) == 0) : (($urandom % 8) != 0);
            don = ($urandom % 200) != 0;
            rst = ($urandom % 500) == 0;
            step(rst, don, rv, rr, prd, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_disp_pixfifo
